// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: ratio load bus between a controller and clk_div_gen.
// Master drives div_in/div_load; slave returns div_ack/div_err pulses.
interface clk_div_gen_if #(
  parameter int NCH   = 2,
  parameter int DIV_W = 8
);
  logic [NCH*DIV_W-1:0] div_in;
  logic [NCH-1:0]       div_load;
  logic [NCH-1:0]       div_ack;
  logic [NCH-1:0]       div_err;

  modport master (
    output div_in,
    output div_load,
    input  div_ack,
    input  div_err
  );

  modport slave (
    input  div_in,
    input  div_load,
    output div_ack,
    output div_err
  );
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: NCH glitch-free programmable clock dividers gated by a
// filtered PLL lock, with per-channel rise/fall strobes.
// Ports:
//   clkin     PLL output clock, all logic on its rising edge
//   rst_n     synchronous active-low reset
//   pll_lock  raw PLL lock (asynchronous)
//   bus       ratio load bus (div_in, div_load, div_ack, div_err)
//   clk_o     divided clocks, registered
//   rise_stb  first high cycle of each clk_o period
//   fall_stb  first low cycle of each clk_o period
//   ready     filtered lock; channels run only while high
module clk_div_gen #(
  parameter int NCH       = 2,
  parameter int DIV_W     = 8,
  parameter int DEF_DIV   = 4,
  parameter int LOCK_FILT = 16
) (
  input  logic           clkin,
  input  logic           rst_n,
  input  logic           pll_lock,
  clk_div_gen_if.slave   bus,
  output logic [NCH-1:0] clk_o,
  output logic [NCH-1:0] rise_stb,
  output logic [NCH-1:0] fall_stb,
  output logic           ready
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam logic [FW-1:0] FMAX =
    FW'(LOCK_FILT);
  localparam logic [DIV_W-1:0] DDEF =
    DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] DMIN =
    DIV_W'(2);

  logic          sync1_q;
  logic          sync2_q;
  logic [FW-1:0] fcnt_q;
  logic [FW-1:0] fcnt_d;
  logic          ready_q;
  logic          ready_d;

  // Counter saturates at LOCK_FILT so ready
  // simply holds while the lock stays high.
  always_comb begin
    fcnt_d = fcnt_q;
    if (!sync2_q)
      fcnt_d = '0;
    else if (fcnt_q != FMAX)
      fcnt_d = fcnt_q + 1'b1;
    ready_d = sync2_q &&
              (ready_q || fcnt_d == FMAX);
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fcnt_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
      fcnt_q  <= fcnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

  logic [NCH-1:0] ack_w;
  logic [NCH-1:0] err_w;

  assign bus.div_ack = ack_w;
  assign bus.div_err = err_w;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DIV_W-1:0] din;
    logic             ld;
    logic             ld_ok;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] act_q;
    logic [DIV_W-1:0] act_d;
    logic [DIV_W-1:0] pend_q;
    logic [DIV_W-1:0] pend_d;
    logic             pv_q;
    logic             pv_d;
    logic             ack_d;
    logic             en;
    logic [DIV_W:0]   half;
    logic [DIV_W:0]   cnt_x;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             ack_q;
    logic             err_q;

    always_comb begin
      din    = bus.div_in[k*DIV_W +: DIV_W];
      ld     = bus.div_load[k];
      ld_ok  = ld && (din >= DMIN);
      cnt_d  = cnt_q;
      act_d  = act_q;
      pend_d = pend_q;
      pv_d   = pv_q;
      ack_d  = 1'b0;
      unique case (1'b1)
        ready_q: begin
          // Ratio changes only at the wrap so
          // no phase is ever truncated. A load
          // on the wrap edge waits one period.
          if (cnt_q == act_q - 1'b1) begin
            cnt_d = '0;
            if (pv_q) begin
              act_d = pend_q;
              pv_d  = 1'b0;
              ack_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (ld_ok) begin
            pend_d = din;
            pv_d   = 1'b1;
          end
        end
        !ready_q: begin
          // Stopped: nothing to glitch, so a
          // ratio is taken over immediately.
          cnt_d = '0;
          if (ld_ok) begin
            act_d = din;
            pv_d  = 1'b0;
            ack_d = 1'b1;
          end else if (pv_q) begin
            act_d = pend_q;
            pv_d  = 1'b0;
            ack_d = 1'b1;
          end
        end
      endcase
      half  = ({1'b0, act_d} + 1'b1) >> 1;
      cnt_x = {1'b0, cnt_d};
      // Outputs run on the cycle ready first
      // rises and stop one cycle after it falls.
      en    = ready_q || ready_d;
    end

    always_ff @(posedge clkin) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        act_q  <= DDEF;
        pend_q <= DDEF;
        pv_q   <= 1'b0;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        ack_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        pend_q <= pend_d;
        pv_q   <= pv_d;
        clk_q  <= en && (cnt_x < half);
        rise_q <= en && (cnt_d == '0);
        fall_q <= en && (cnt_x == half);
        ack_q  <= ack_d;
        err_q  <= ld && !ld_ok;
      end
    end

    assign clk_o[k]    = clk_q;
    assign rise_stb[k] = rise_q;
    assign fall_stb[k] = fall_q;
    assign ack_w[k]    = ack_q;
    assign err_w[k]    = err_q;
  end

endmodule
